// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for the pipelined logic unit: issue side (in_*) and result side (out_*).
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  // Issue logic / consumer side
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_tag
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_tag
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides and a sideband tag.
// S1 captures the operands, S2 holds the computed result; outputs come straight from S2.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_ANDN  = 3'b110,
    OP_PASSA = 3'b111
  } op_e;

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_zero_q, s2_zero_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             s1_load_c;
  logic             s2_load_c;
  logic [WIDTH-1:0] result_c;

  // Advance conditions: a stage moves when it is empty or its downstream moves
  always_comb begin
    s2_adv_c  = !s2_valid_q || bus.out_ready;
    s1_adv_c  = !s1_valid_q || s2_adv_c;
    s1_load_c = s1_adv_c && bus.in_valid;
    s2_load_c = s2_adv_c && s1_valid_q;
  end

  // Bitwise operation on the S1 operands
  always_comb begin
    result_c = '0;
    unique case (s1_op_q)
      OP_AND:   result_c = s1_a_q & s1_b_q;
      OP_OR:    result_c = s1_a_q | s1_b_q;
      OP_XOR:   result_c = s1_a_q ^ s1_b_q;
      OP_NAND:  result_c = ~(s1_a_q & s1_b_q);
      OP_NOR:   result_c = ~(s1_a_q | s1_b_q);
      OP_XNOR:  result_c = ~(s1_a_q ^ s1_b_q);
      OP_ANDN:  result_c = s1_a_q & ~s1_b_q;
      OP_PASSA: result_c = s1_a_q;
    endcase
  end

  // Next state: valids follow the advance, data only load on a real transfer
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;
    s2_tag_d    = s2_tag_q;

    if (s1_adv_c) s1_valid_d = bus.in_valid;
    if (s1_load_c) begin
      s1_op_d  = op_e'(bus.in_op);
      s1_a_d   = bus.in_a;
      s1_b_d   = bus.in_b;
      s1_tag_d = bus.in_tag;
    end

    if (s2_adv_c) s2_valid_d = s1_valid_q;
    if (s2_load_c) begin
      s2_result_d = result_c;
      s2_zero_d   = ~|result_c;
      s2_tag_d    = s1_tag_q;
    end
  end

  // Pipeline registers, cleared asynchronously; in-flight work is dropped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_AND;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

  // in_ready is combinational from out_ready; out_* come only from S2 registers
  assign bus.in_ready   = s1_adv_c;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_result_q;
  assign bus.out_zero   = s2_zero_q;
  assign bus.out_tag    = s2_tag_q;

endmodule
